param_regfile_dump: RTL and testbench
=====================================

Name: param_regfile_dump

Overview:
- Parametrised successor to the processor's 32x32 general-purpose register file.
- Generalised in data width, depth and number of read ports; adds:
  - byte-enable writes
  - optional write-to-read bypass
  - optional hardwired zero register
  - cycle-accurate register-dump streaming port (valid/ready) replacing simulation file dumps, for debug/trace capture by the testbench or an on-chip logger.
- Sits in the decode stage between instruction decode and the ALU operand muxes.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_we  in  1  write enable.
- i_waddr  in  ADDR_W  write address.
- i_wdata  in  DATA_W  write data.
- i_wbe  in  DATA_W/8  byte enables; bit b covers data bits [8b+7:8b].
- i_raddr  in  NUM_RD*ADDR_W  packed read addresses; port p uses slice p.
- o_rdata  out  NUM_RD*DATA_W  packed read data; combinational.
- i_dump_req  in  1  start a full-file dump (pulse or level).
- o_dump_valid  out  1  dump beat valid.
- i_dump_ready  in  1  consumer accepts beat.
- o_dump_idx  out  ADDR_W  register index of current beat.
- o_dump_data  out  DATA_W  register value of current beat (registered).
- o_dump_last  out  1  high on the beat with idx = DEPTH-1.
- o_dump_busy  out  1  high from dump start until last beat is accepted.

Behaviour:
- Clock and reset: single clock i_clk; reset is synchronous and active-low (i_rst_n). Reset takes effect at a rising edge with i_rst_n=0.
- Reset state: all registers = 0; dump FSM = IDLE; o_dump_valid, o_dump_last, o_dump_busy = 0; o_dump_idx = 0; o_dump_data = 0.
- Reset mid-dump: aborts the dump immediately; no further beats are issued.
- Write:
  - When i_we=1, at the clock edge each byte b with i_wbe[b]=1 of reg[i_waddr] takes i_wdata's byte b; other bytes hold.
  - i_we=1 with i_wbe=0 is a no-op.
  - ZERO_REG=1 with i_waddr=0: write discarded.
- Read:
  - Combinational, zero latency.
  - Port p returns reg[addr_p], or 0 if ZERO_REG=1 and addr_p=0.
  - BYPASS=1 and i_we=1 and addr_p=i_waddr (and not the zero register): returns the merged value, i.e. written bytes from i_wdata and the remaining bytes from reg.
  - BYPASS=0: returns the old stored value; the new value is visible the next cycle.
- Dump FSM, states IDLE and STREAM:
  - IDLE + i_dump_req=1 -> STREAM. Next cycle: o_dump_valid=1, idx=0, data=value of reg[0], busy=1.
  - STREAM, valid & ready, idx<DEPTH-1: idx+1; data loads the value of reg[idx+1] the same edge. Back-to-back beats give one beat per cycle.
  - STREAM, valid & ready, idx=DEPTH-1 (o_dump_last=1): -> IDLE; valid, last, busy = 0.
  - STREAM, valid & !ready: idx, data and last are held stable, even if a write hits that index.
  - i_dump_req in STREAM is ignored. A level-held req restarts one cycle after return to IDLE.
  - Captured dump value follows the read-port bypass rule:
    - with BYPASS=1, a write landing on the index being loaded that edge is captured with its merged value;
    - with BYPASS=0, the pre-write value is captured.
  - Captured value for reg 0 obeys ZERO_REG.
- Writes and reads are fully independent of the dump; no stalls are generated.
- Minimum dump duration: DEPTH cycles with ready held high.

Decomposition:
- Shared package regfile_pkg:
  - dump state enum {DUMP_IDLE, DUMP_STREAM};
  - function byte_merge(old, new, be) used by the write path, bypass and dump capture;
  - default width constants.
- One sub-module: regfile_dump_ctrl. It holds the FSM, index counter and valid/ready/last logic, and outputs the next capture index. The top module owns the array and the merge/bypass muxes.

Test Plan:
- Reset/zero: after reset, read every index on every port -> 0. Write 0xDEADBEEF to r0 with ZERO_REG=1 -> r0 reads 0.
- Byte-enable: write r5=0x11223344 with be=0xF, then 0xAABBCCDD with be=0x5 -> r5 reads 0x11BB33DD.
- Bypass: same cycle as i_we=1, waddr=7, wdata=0xCAFEF00D, be=0xF, port1 raddr=7 -> o_rdata port1 = 0xCAFEF00D that cycle (BYPASS=1). With BYPASS=0 -> old value, new value the next cycle.
- Dump full throughput: reg[i]=i*0x01010101, req pulse, ready=1 -> 32 consecutive beats, idx 0..31 with matching data, last only on idx 31, busy low the cycle after.
- Dump backpressure: ready low for 3 cycles on idx 4 while writing r4=0x55 -> idx/data stay 4/0x04040404. Resume gives the remaining beats in order.
- Reset mid-dump: i_rst_n=0 at idx 10 -> next cycle valid=0, busy=0, all regs 0. A new req dumps all zeros from idx 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, default widths and the byte-merge helper for the
// parametrised register file and its dump controller.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic [0:0] {
    DUMP_IDLE   = 1'b0,
    DUMP_STREAM = 1'b1
  } dump_state_e;

  // Merge one byte lane: enabled lanes take the incoming byte, others keep
  // the stored byte. Used by the write path, read bypass and dump capture.
  function automatic logic [7:0] byte_merge(
    input logic [7:0] old_byte,
    input logic [7:0] wr_byte,
    input logic       be
  );
    logic [7:0] res;
    if (be) begin
      res = wr_byte;
    end else begin
      res = old_byte;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump streaming controller: walks every register index once per request,
// presenting one valid/ready beat per index, and tells the top which index
// to capture into the dump data register on each edge.
module regfile_dump_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dump_req,
  input  logic              i_dump_ready,
  output logic              o_dump_valid,
  output logic              o_dump_last,
  output logic              o_dump_busy,
  output logic [ADDR_W-1:0] o_dump_idx,
  output logic              o_cap_en,
  output logic [ADDR_W-1:0] o_cap_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  dump_state_e       state_r;
  dump_state_e       state_nxt_s;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] idx_nxt_s;
  logic              valid_r;
  logic              last_r;
  logic              cap_en_s;
  logic [ADDR_W-1:0] cap_idx_s;

  // Next-state, next-index and capture strobe for the dump walk.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cap_en_s    = 1'b0;
    cap_idx_s   = idx_r;
    case (state_r)
      DUMP_IDLE: begin
        if (i_dump_req) begin
          state_nxt_s = DUMP_STREAM;
          idx_nxt_s   = '0;
          cap_en_s    = 1'b1;
          cap_idx_s   = '0;
        end else begin
          state_nxt_s = DUMP_IDLE;
          idx_nxt_s   = idx_r;
        end
      end
      DUMP_STREAM: begin
        if (i_dump_ready) begin
          if (idx_r == LAST_IDX) begin
            state_nxt_s = DUMP_IDLE;
            idx_nxt_s   = '0;
          end else begin
            idx_nxt_s   = idx_r + ADDR_W'(1);
            cap_en_s    = 1'b1;
            cap_idx_s   = idx_r + ADDR_W'(1);
          end
        end else begin
          // Backpressure: beat contents stay frozen.
          state_nxt_s = DUMP_STREAM;
          idx_nxt_s   = idx_r;
        end
      end
      default: begin
        state_nxt_s = DUMP_IDLE;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // State, index and registered handshake outputs; reset aborts any dump.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= DUMP_IDLE;
      idx_r   <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      valid_r <= (state_nxt_s == DUMP_STREAM);
      last_r  <= (state_nxt_s == DUMP_STREAM) && (idx_nxt_s == LAST_IDX);
    end
  end

  assign o_dump_valid = valid_r;
  assign o_dump_busy  = valid_r;
  assign o_dump_last  = last_r;
  assign o_dump_idx   = idx_r;
  assign o_cap_en     = cap_en_s;
  assign o_cap_idx    = cap_idx_s;

endmodule

// File: rtl/param_regfile_dump.sv
// Parametrised general-purpose register file with byte-enable writes,
// optional write-to-read bypass, optional hardwired zero register and a
// valid/ready register-dump stream for trace capture.
module param_regfile_dump
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [DATA_W/8-1:0]      i_wbe,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  input  logic                     i_dump_req,
  output logic                     o_dump_valid,
  input  logic                     i_dump_ready,
  output logic [ADDR_W-1:0]        o_dump_idx,
  output logic [DATA_W-1:0]        o_dump_data,
  output logic                     o_dump_last,
  output logic                     o_dump_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] wmerge_s;
  logic              wr_en_s;
  logic              cap_en_s;
  logic [ADDR_W-1:0] cap_idx_s;
  logic [DATA_W-1:0] dump_data_r;

  // Lookup slots: one per read port plus a final slot for dump capture, so
  // the dump observes exactly the same zero/bypass rule as the read ports.
  logic [ADDR_W-1:0] rd_addr_s [NUM_RD+1];
  logic [DATA_W-1:0] rd_val_s  [NUM_RD+1];

  // Merged write value: enabled bytes from write data, the rest from storage.
  always_comb begin
    wmerge_s = '0;
    for (int b = 0; b < NB; b++) begin
      wmerge_s[8*b +: 8] = byte_merge(mem_r[i_waddr][8*b +: 8], i_wdata[8*b +: 8], i_wbe[b]);
    end
  end

  // Writes to the hardwired zero register are dropped.
  assign wr_en_s = i_we && !(ZERO_REG && (i_waddr == '0));

  // Register array update; reset clears every entry.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!i_rst_n) begin
        mem_r[i] <= '0;
      end else if (wr_en_s && (i_waddr == ADDR_W'(i))) begin
        mem_r[i] <= wmerge_s;
      end else begin
        mem_r[i] <= mem_r[i];
      end
    end
  end

  // Unpack read addresses and append the dump capture index.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr_s[p] = i_raddr[p*ADDR_W +: ADDR_W];
    end
    rd_addr_s[NUM_RD] = cap_idx_s;
  end

  for (genvar p = 0; p <= NUM_RD; p++) begin : g_rd
    assign rd_val_s[p] = (ZERO_REG && (rd_addr_s[p] == '0))             ? '0 :
                         (BYPASS && i_we && (rd_addr_s[p] == i_waddr)) ? wmerge_s :
                                                                         mem_r[rd_addr_s[p]];
  end

  // Pack the per-port read values onto the output bus.
  always_comb begin
    o_rdata = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      o_rdata[p*DATA_W +: DATA_W] = rd_val_s[p];
    end
  end

  regfile_dump_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_dump_ctrl (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_dump_req   (i_dump_req),
    .i_dump_ready (i_dump_ready),
    .o_dump_valid (o_dump_valid),
    .o_dump_last  (o_dump_last),
    .o_dump_busy  (o_dump_busy),
    .o_dump_idx   (o_dump_idx),
    .o_cap_en     (cap_en_s),
    .o_cap_idx    (cap_idx_s)
  );

  // Dump data register: loads the next beat's value, holds under backpressure.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dump_data_r <= '0;
    end else if (cap_en_s) begin
      dump_data_r <= rd_val_s[NUM_RD];
    end else begin
      dump_data_r <= dump_data_r;
    end
  end

  assign o_dump_data = dump_data_r;

endmodule

// File: tb/tb_param_regfile_dump.sv
// Self-checking bench: two register files (bypass+zero-reg, and plain) share
// stimulus; a behavioural model predicts reads and dump beats every cycle.
module tb_param_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n, we, req, ready;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [9:0]  raddr;

  logic        dv [2];
  logic        dl [2];
  logic        db [2];
  logic [4:0]  di [2];
  logic [31:0] dd [2];
  logic [63:0] rd [2];

  // Next-cycle stimulus, applied to the DUT pins at the falling edge.
  logic        n_rst_n, n_we, n_req, n_ready;
  logic [4:0]  n_waddr;
  logic [31:0] n_wdata;
  logic [3:0]  n_wbe;
  logic [9:0]  n_raddr;

  // Reference model state. Instance 0: ZERO_REG=1, BYPASS=1. Instance 1: both 0.
  logic [31:0] m [2][32];
  bit          exp_act;
  bit          exp_clean;
  int          exp_idx;
  logic [31:0] exp_data [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_regfile_dump #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_byp (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_wbe(wbe),
    .i_raddr(raddr), .o_rdata(rd[0]), .i_dump_req(req), .o_dump_valid(dv[0]),
    .i_dump_ready(ready), .o_dump_idx(di[0]), .o_dump_data(dd[0]), .o_dump_last(dl[0]),
    .o_dump_busy(db[0]));

  param_regfile_dump #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_plain (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_wbe(wbe),
    .i_raddr(raddr), .o_rdata(rd[1]), .i_dump_req(req), .o_dump_valid(dv[1]),
    .i_dump_ready(ready), .o_dump_idx(di[1]), .o_dump_data(dd[1]), .o_dump_last(dl[1]),
    .o_dump_busy(db[1]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value a write in progress would leave in the addressed register.
  function automatic logic [31:0] merged(input int k);
    logic [31:0] v;
    v = m[k][waddr];
    for (int b = 0; b < 4; b++) begin
      if (wbe[b]) v[8*b +: 8] = wdata[8*b +: 8];
    end
    return v;
  endfunction

  // Spec read rule for instance k at address a, given the current pins.
  function automatic logic [31:0] mread(input int k, input logic [4:0] a);
    if (k == 0 && a == 5'd0) return 32'h0;
    if (k == 0 && we && a == waddr) return merged(k);
    return m[k][a];
  endfunction

  // Advance the model across one rising edge using the pin values.
  task automatic model_edge();
    logic [31:0] wv [2];
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
        exp_data[k] = 32'h0;
      end
      exp_act   = 1'b0;
      exp_clean = 1'b1;
      exp_idx   = 0;
    end else begin
      if (!exp_act) begin
        if (req) begin
          exp_act   = 1'b1;
          exp_clean = 1'b0;
          exp_idx   = 0;
          for (int k = 0; k < 2; k++) exp_data[k] = mread(k, 5'd0);
        end
      end else if (ready) begin
        if (exp_idx == 31) begin
          exp_act = 1'b0;
        end else begin
          exp_idx++;
          for (int k = 0; k < 2; k++) exp_data[k] = mread(k, exp_idx[4:0]);
        end
      end
      for (int k = 0; k < 2; k++) wv[k] = merged(k);
      for (int k = 0; k < 2; k++) begin
        if (we && !(k == 0 && waddr == 5'd0)) m[k][waddr] = wv[k];
      end
    end
  endtask

  // One clock: check registered dump outputs, apply stimulus, check reads.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("dump_valid[%0d]", k), {31'b0, dv[k]}, {31'b0, exp_act});
      check_val($sformatf("dump_busy[%0d]", k), {31'b0, db[k]}, {31'b0, exp_act});
      check_val($sformatf("dump_last[%0d]", k), {31'b0, dl[k]}, {31'b0, exp_act && exp_idx == 31});
      if (exp_act || exp_clean) begin
        check_val($sformatf("dump_idx[%0d]", k), {27'b0, di[k]}, exp_idx);
        check_val($sformatf("dump_data[%0d]", k), dd[k], exp_data[k]);
      end
    end
    rst_n = n_rst_n; we = n_we; req = n_req; ready = n_ready;
    waddr = n_waddr; wdata = n_wdata; wbe = n_wbe; raddr = n_raddr;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        check_val($sformatf("rdata[%0d].p%0d a=%0d", k, p, raddr[p*5 +: 5]),
                  rd[k][p*32 +: 32], mread(k, raddr[p*5 +: 5]));
      end
    end
    @(posedge clk);
    model_edge();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    n_we = 1'b1; n_waddr = a; n_wdata = d; n_wbe = be;
    step();
    n_we = 1'b0;
  endtask

  task automatic run_to_idx(input int target);
    int cnt;
    cnt = 0;
    while (!(exp_act && exp_idx == target) && cnt < 64) begin
      step();
      cnt++;
    end
    if (cnt >= 64) check_val("dump_reach_idx", 32'(exp_idx), 32'(target));
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; req = 1'b0; ready = 1'b1;
    waddr = 5'd0; wdata = 32'h0; wbe = 4'h0; raddr = 10'h0;
    n_rst_n = 1'b0; n_we = 1'b0; n_req = 1'b0; n_ready = 1'b1;
    n_waddr = 5'd0; n_wdata = 32'h0; n_wbe = 4'h0; n_raddr = 10'h0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
      exp_data[k] = 32'h0;
    end
    exp_act = 1'b0; exp_clean = 1'b1; exp_idx = 0;

    // Reset, then sweep all addresses on both ports.
    step(); step();
    n_rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      n_raddr = {5'(31 - i), 5'(i)};
      step();
    end

    // Zero register write, byte enables on r5, same-cycle bypass on r7.
    n_raddr = {5'd0, 5'd0};
    wr(5'd0, 32'hDEADBEEF, 4'hF);
    step();
    n_raddr = {5'd5, 5'd5};
    wr(5'd5, 32'h11223344, 4'hF);
    wr(5'd5, 32'hAABBCCDD, 4'h5);
    step();
    n_raddr = {5'd7, 5'd0};
    wr(5'd7, 32'h00000001, 4'hF);
    wr(5'd7, 32'hCAFEF00D, 4'hF);
    step();
    wr(5'd9, 32'h12345678, 4'h0);
    n_raddr = {5'd9, 5'd9};
    step();

    // Full-throughput dump of reg[i] = i * 0x01010101.
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101, 4'hF);
    n_req = 1'b1; step(); n_req = 1'b0;
    repeat (34) step();

    // Backpressure at idx 4 while r4 is overwritten.
    n_req = 1'b1; step(); n_req = 1'b0;
    run_to_idx(4);
    n_ready = 1'b0;
    wr(5'd4, 32'h00000055, 4'hF);
    step(); step();
    n_ready = 1'b1;
    repeat (32) step();

    // Level-held request restarts after the last beat.
    n_req = 1'b1;
    repeat (36) step();
    n_req = 1'b0;
    repeat (34) step();

    // Reset in the middle of a dump, then dump the cleared file.
    n_req = 1'b1; step(); n_req = 1'b0;
    run_to_idx(10);
    n_rst_n = 1'b0; step();
    n_rst_n = 1'b1; step();
    n_req = 1'b1; step(); n_req = 1'b0;
    repeat (34) step();

    // Randomised traffic with dumps, backpressure and occasional reset.
    for (int t = 0; t < 3000; t++) begin
      n_rst_n = ($urandom_range(0, 299) != 0);
      n_we    = $urandom_range(0, 1) == 1;
      n_waddr = 5'($urandom_range(0, 31));
      n_wdata = $urandom;
      n_wbe   = 4'($urandom_range(0, 15));
      n_raddr = ($urandom_range(0, 3) == 0) ? {n_waddr, n_waddr} : 10'($urandom_range(0, 1023));
      n_req   = ($urandom_range(0, 7) == 0);
      n_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
